// File: rtl/fp_pkg.sv
// Shared types and constant helpers for the pipelined floating-point adder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fp_pkg;

    // Operand classification; denormals are flushed into FP_ZERO.
    typedef enum logic [1:0] {
        FP_ZERO,
        FP_NORM,
        FP_INF,
        FP_NAN
    } fp_class_t;

    // Issue-to-done latency in clock cycles.
    localparam int LATENCY = 4;

    // Special-value outcome, resolved at unpack time and carried to the pack stage.
    typedef struct packed {
        logic is_nan;     // any NaN operand, or +INF + -INF
        logic is_inf;     // at least one INF operand (and no NaN)
        logic inf_sign;   // effective sign of that INF
        logic is_zero;    // both operands zero
        logic zero_sign;  // sign of a zero+zero sum (-0 only for -0 + -0)
    } fp_spec_t;

    // Per-op control payload travelling down the pipeline alongside the datapath.
    typedef struct packed {
        logic     sign_l;   // sign of the larger-magnitude operand
        logic     eff_sub;  // operand signs differ after the sub adjustment
        fp_spec_t spec;
    } fp_ctl_t;

    function automatic logic [63:0] fp_bias(input int exp_w);
        return (64'd1 << (exp_w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] fp_exp_ones(input int exp_w);
        return (64'd1 << exp_w) - 64'd1;
    endfunction

    // Canonical quiet NaN: {0, all-ones exponent, 1 followed by zeros}.
    function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
        return (fp_exp_ones(exp_w) << man_w) | (64'd1 << (man_w - 1));
    endfunction

endpackage

// File: rtl/fp_add_pipe_lzc.sv
// Combinational leading-zero counter; an all-zero input yields WIDTH.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: din = vector to scan (MSB first), cnt = number of leading zeros.
module fp_lzc #(
    parameter  int WIDTH = 27,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] din,
    output logic [CW-1:0]    cnt
);

    // Scan from LSB upward so the highest set bit is the last one to win.
    always_comb begin
        cnt = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (din[i]) begin
                cnt = CW'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp_add_pipe.sv
// Pipelined IEEE-754 style adder/subtractor: unpack, align, add, normalise/pack.
// Latency: op accepted at edge N (_go=1, stall=0) gives done/Result after edge N+4; 1 op/cycle.
// Backpressure: stall=1 freezes every stage and the output; _go is ignored while stalled.
// Optional build macro FP_ADD_ROUND_EN: round-to-nearest-even; otherwise truncate.
// Ports: clk, reset (sync, active-high), _go (op valid), stall (global freeze),
//        sub (1: Number1-Number2), Number1/Number2 (operands), Result (sum), done (result valid).
module fp_add_pipe
    import fp_pkg::*;
#(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 23,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         _go,
    input  logic         stall,
    input  logic         sub,
    input  logic [W-1:0] Number1,
    input  logic [W-1:0] Number2,
    output logic [W-1:0] Result,
    output logic         done
);

    localparam int GW  = MAN_W + 4;          // hidden + fraction + guard/round/sticky
    localparam int SW  = GW + 1;             // plus carry
    localparam int LZW = $clog2(GW + 1);
    localparam int EW  = EXP_W + 2;          // room for exponent over/underflow (two's complement)
    localparam logic [EXP_W-1:0] EXP_ONES = EXP_W'(fp_exp_ones(EXP_W));
    localparam logic [W-1:0]     QNAN     = W'(fp_qnan(EXP_W, MAN_W));

    logic advance;
    assign advance = !stall;

    function automatic fp_class_t classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
        if (e == '0) begin
            return FP_ZERO;
        end else if (e == EXP_ONES) begin
            return (f == '0) ? FP_INF : FP_NAN;
        end else begin
            return FP_NORM;
        end
    endfunction

    // ---------------- operand capture ----------------
    logic         s0_vld;
    logic [W-1:0] s0_a;
    logic [W-1:0] s0_b;
    logic         s0_sub;

    always_ff @(posedge clk) begin
        if (reset) begin
            s0_vld <= 1'b0;
        end else if (advance) begin
            s0_vld <= _go;
            s0_a   <= Number1;
            s0_b   <= Number2;
            s0_sub <= sub;
        end
    end

    // ---------------- S1: unpack / classify / swap ----------------
    logic             sign_a, sign_b;
    logic [EXP_W-1:0] exp_a, exp_b;
    logic [MAN_W-1:0] frac_a, frac_b;
    fp_class_t        cls_a, cls_b;
    logic [MAN_W:0]   man_a, man_b;
    logic             a_is_l;
    logic [EXP_W-1:0] c1_exp_l, c1_exp_s;
    logic [MAN_W:0]   c1_man_l, c1_man_s;
    fp_ctl_t          c1_ctl;

    assign sign_a = s0_a[W-1];
    assign exp_a  = s0_a[W-2:MAN_W];
    assign frac_a = s0_a[MAN_W-1:0];
    assign sign_b = s0_b[W-1] ^ s0_sub;
    assign exp_b  = s0_b[W-2:MAN_W];
    assign frac_b = s0_b[MAN_W-1:0];
    assign cls_a  = classify(exp_a, frac_a);
    assign cls_b  = classify(exp_b, frac_b);
    assign man_a  = (cls_a == FP_NORM) ? {1'b1, frac_a} : '0;
    assign man_b  = (cls_b == FP_NORM) ? {1'b1, frac_b} : '0;
    assign a_is_l = {exp_a, man_a} >= {exp_b, man_b};

    always_comb begin
        if (a_is_l) begin
            c1_exp_l      = exp_a;
            c1_exp_s      = exp_b;
            c1_man_l      = man_a;
            c1_man_s      = man_b;
            c1_ctl.sign_l = sign_a;
        end else begin
            c1_exp_l      = exp_b;
            c1_exp_s      = exp_a;
            c1_man_l      = man_b;
            c1_man_s      = man_a;
            c1_ctl.sign_l = sign_b;
        end
        c1_ctl.eff_sub        = sign_a ^ sign_b;
        c1_ctl.spec.is_nan    = (cls_a == FP_NAN) || (cls_b == FP_NAN) ||
                                ((cls_a == FP_INF) && (cls_b == FP_INF) && (sign_a != sign_b));
        c1_ctl.spec.is_inf    = (cls_a == FP_INF) || (cls_b == FP_INF);
        c1_ctl.spec.inf_sign  = (cls_a == FP_INF) ? sign_a : sign_b;
        c1_ctl.spec.is_zero   = (cls_a == FP_ZERO) && (cls_b == FP_ZERO);
        c1_ctl.spec.zero_sign = sign_a & sign_b;
    end

    logic             s1_vld;
    fp_ctl_t          s1_ctl;
    logic [EXP_W-1:0] s1_exp_l, s1_d;
    logic [MAN_W:0]   s1_man_l, s1_man_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld <= 1'b0;
        end else if (advance) begin
            s1_vld   <= s0_vld;
            s1_ctl   <= c1_ctl;
            s1_exp_l <= c1_exp_l;
            s1_d     <= c1_exp_l - c1_exp_s;
            s1_man_l <= c1_man_l;
            s1_man_s <= c1_man_s;
        end
    end

    // ---------------- S2: align smaller operand ----------------
    logic [GW-1:0] ext_s, shifted, c2_man_s;
    logic          lost;

    assign ext_s    = {s1_man_s, 3'b000};
    assign shifted  = ext_s >> s1_d;
    assign lost     = |(ext_s & ~({GW{1'b1}} << s1_d));
    // Far-apart exponents collapse the small operand into the sticky bit alone.
    assign c2_man_s = (32'(s1_d) >= MAN_W + 3) ? {{(GW-1){1'b0}}, |s1_man_s}
                                               : {shifted[GW-1:1], shifted[0] | lost};

    logic             s2_vld;
    fp_ctl_t          s2_ctl;
    logic [EXP_W-1:0] s2_exp_l;
    logic [GW-1:0]    s2_man_l, s2_man_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_vld <= 1'b0;
        end else if (advance) begin
            s2_vld   <= s1_vld;
            s2_ctl   <= s1_ctl;
            s2_exp_l <= s1_exp_l;
            s2_man_l <= {s1_man_l, 3'b000};
            s2_man_s <= c2_man_s;
        end
    end

    // ---------------- S3: add / subtract + leading-zero count ----------------
    // L >= S in magnitude, so the subtraction never goes negative.
    logic [SW-1:0]  c3_sum;
    logic [LZW-1:0] c3_lz;

    assign c3_sum = s2_ctl.eff_sub ? ({1'b0, s2_man_l} - {1'b0, s2_man_s})
                                   : ({1'b0, s2_man_l} + {1'b0, s2_man_s});

    fp_lzc #(.WIDTH(GW)) u_lzc (
        .din (c3_sum[GW-1:0]),
        .cnt (c3_lz)
    );

    logic             s3_vld;
    logic             s3_sign;
    fp_spec_t         s3_spec;
    logic [EXP_W-1:0] s3_exp;
    logic [SW-1:0]    s3_sum;
    logic [LZW-1:0]   s3_lz;

    always_ff @(posedge clk) begin
        if (reset) begin
            s3_vld <= 1'b0;
        end else if (advance) begin
            s3_vld  <= s2_vld;
            s3_sign <= s2_ctl.sign_l;
            s3_spec <= s2_ctl.spec;
            s3_exp  <= s2_exp_l;
            s3_sum  <= c3_sum;
            s3_lz   <= c3_lz;
        end
    end

    // ---------------- S4: normalise / round / pack ----------------
    logic [GW-1:0]    norm;
    logic [EW-1:0]    e_n, e_f;
    logic [MAN_W:0]   mant;
    logic [MAN_W-1:0] frac_f;
    logic [W-1:0]     c4_res;

    always_comb begin
        if (s3_sum[GW]) begin
            // Carry out: shift right once, folding the dropped bit into sticky.
            norm = {s3_sum[GW:2], s3_sum[1] | s3_sum[0]};
            e_n  = EW'(s3_exp) + EW'(1);
        end else begin
            norm = s3_sum[GW-1:0] << s3_lz;
            e_n  = EW'(s3_exp) - EW'(s3_lz);
        end
    end

    assign mant = norm[GW-1:3];

`ifdef FP_ADD_ROUND_EN
    logic             rnd_inc;
    logic [MAN_W+1:0] mr;

    assign rnd_inc = norm[2] & (norm[1] | norm[0] | mant[0]);
    assign mr      = {1'b0, mant} + {{(MAN_W+1){1'b0}}, rnd_inc};
    // Rounding can carry into a new leading bit: renormalise once more.
    assign frac_f  = mr[MAN_W+1] ? mr[MAN_W:1] : mr[MAN_W-1:0];
    assign e_f     = mr[MAN_W+1] ? (e_n + EW'(1)) : e_n;
`else
    // Truncation: guard/round/sticky are produced upstream but not consumed here.
    logic unused_grs;

    assign unused_grs = ^{mant[MAN_W], norm[2:0]};
    assign frac_f     = mant[MAN_W-1:0];
    assign e_f        = e_n;
`endif

    always_comb begin
        c4_res = {s3_sign, e_f[EXP_W-1:0], frac_f};
        if (s3_spec.is_nan) begin
            c4_res = QNAN;
        end else if (s3_spec.is_inf) begin
            c4_res = {s3_spec.inf_sign, EXP_ONES, {MAN_W{1'b0}}};
        end else if (s3_spec.is_zero) begin
            c4_res = {s3_spec.zero_sign, {(W-1){1'b0}}};
        end else if (s3_sum == '0) begin
            c4_res = '0;  // exact cancellation is +0
        end else if (!e_f[EW-1] && (e_f >= EW'(EXP_ONES))) begin
            c4_res = {s3_sign, EXP_ONES, {MAN_W{1'b0}}};
        end else if (e_f[EW-1] || (e_f == '0)) begin
            c4_res = {s3_sign, {(W-1){1'b0}}};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            done   <= 1'b0;
            Result <= '0;
        end else if (advance) begin
            done <= s3_vld;
            if (s3_vld) begin
                Result <= c4_res;
            end
        end
    end

endmodule

// File: tb/tb_fp_add_pipe.sv
// Directed bench for fp_add_pipe with a result scoreboard.
module tb_fp_add_pipe;
    import fp_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        go;
    logic        stall;
    logic        sub;
    logic [31:0] n1, n2;
    logic [31:0] res;
    logic        done;

    always #5 clk = ~clk;

    fp_add_pipe dut (
        .clk     (clk),
        .reset   (reset),
        ._go     (go),
        .stall   (stall),
        .sub     (sub),
        .Number1 (n1),
        .Number2 (n2),
        .Result  (res),
        .done    (done)
    );

`ifdef FP_ADD_ROUND_EN
    localparam logic [31:0] EXP_GR    = 32'h3F800001;
    localparam logic [31:0] EXP_CARRY = 32'h3F800000;
`else
    localparam logic [31:0] EXP_GR    = 32'h3F800000;
    localparam logic [31:0] EXP_CARRY = 32'h3F7FFFFF;
`endif

    localparam int NB = 20;
    logic [31:0] tab_a [NB] = '{32'h3FC00000, 32'h80000000, 32'h7F800000, 32'h7F800000,
                                32'h7FA00000, 32'h7F7FFFFF, 32'h3F800000, 32'h3F800000,
                                32'h40000000, 32'h7F800000, 32'h3FC00000, 32'h40400000,
                                32'h00000000, 32'h00000001, 32'h00800001, 32'h3F000000,
                                32'hFF800000, 32'h3F800000, 32'h3F7FFFFF, 32'h7F800000};
    logic [31:0] tab_b [NB] = '{32'hBFC00000, 32'h80000000, 32'hFF800000, 32'h3F800000,
                                32'h3F800000, 32'h7F7FFFFF, 32'h33C00000, 32'h33800000,
                                32'h3F800000, 32'h7F800000, 32'h40200000, 32'h3F000000,
                                32'hC0A00000, 32'h3F800000, 32'h00800000, 32'h40400000,
                                32'h3F800000, 32'hFF800000, 32'h33000000, 32'h7F800000};
    logic        tab_s [NB] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
                                1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] tab_e [NB] = '{32'h00000000, 32'h80000000, 32'h7FC00000, 32'h7F800000,
                                32'h7FC00000, 32'h7F800000, EXP_GR,       32'h3F800000,
                                32'h3F800000, 32'h7FC00000, 32'h40800000, 32'h40200000,
                                32'hC0A00000, 32'h3F800000, 32'h00000000, 32'hC0200000,
                                32'hFF800000, 32'h7F800000, EXP_CARRY,    32'h7F800000};

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q [$];
    logic [31:0] mon_exp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Called at a negedge with stall low; op is accepted at the next posedge.
    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [31:0] expv);
        go  = 1'b1;
        n1  = a;
        n2  = b;
        sub = s;
        exp_q.push_back(expv);
        @(negedge clk);
        go = 1'b0;
    endtask

    // Consumer: a result is taken when done is high and the pipe is not stalled.
    always @(negedge clk) begin
        if (!reset && done && !stall) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", {31'b0, done}, 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("result", res, mon_exp);
            end
        end
    end

    initial begin
        reset = 1'b1;
        go    = 1'b0;
        stall = 1'b0;
        sub   = 1'b0;
        n1    = '0;
        n2    = '0;
        repeat (2) @(negedge clk);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_result", res, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_done", {31'b0, done}, 32'd0);
        chk("post_reset_result", res, 32'd0);

        // Latency: 1.0 + 1.0, done exactly LATENCY edges after acceptance.
        drive(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk("latency_done", {31'b0, done}, (k == LATENCY) ? 32'd1 : 32'd0);
        end

        // Back-to-back burst of directed cases.
        for (int i = 0; i < NB; i++) begin
            drive(tab_a[i], tab_b[i], tab_s[i], tab_e[i]);
        end
        repeat (10) @(negedge clk);
        chk("burst_drain", 32'(exp_q.size()), 32'd0);

        // done and Result hold while stalled.
        drive(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000);
        repeat (4) @(posedge clk);
        #1 stall = 1'b1;
        @(negedge clk);
        chk("stall_first_done", {31'b0, done}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("stall_hold_done", {31'b0, done}, 32'd1);
        chk("stall_hold_result", res, 32'h40000000);
        @(posedge clk);
        #1 stall = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("stall_release_done", {31'b0, done}, 32'd0);

        // A, B, C back-to-back with a two-cycle stall after B; C is held.
        go = 1'b1; n1 = 32'h3F800000; n2 = 32'h3F800000; sub = 1'b0;
        exp_q.push_back(32'h40000000);
        @(negedge clk);
        n1 = 32'h3FC00000; n2 = 32'h40200000; sub = 1'b0;
        exp_q.push_back(32'h40800000);
        @(negedge clk);
        n1 = 32'h40400000; n2 = 32'h3F000000; sub = 1'b1; stall = 1'b1;
        exp_q.push_back(32'h40200000);
        @(negedge clk);
        @(negedge clk);
        stall = 1'b0;
        @(negedge clk);
        go = 1'b0;
        repeat (10) @(negedge clk);
        chk("abc_drain", 32'(exp_q.size()), 32'd0);

        // Same sequence, but reset lands during the stall: nothing may complete.
        go = 1'b1; n1 = 32'h3F800000; n2 = 32'h3F800000; sub = 1'b0;
        @(negedge clk);
        n1 = 32'h3FC00000; n2 = 32'h40200000;
        @(negedge clk);
        n1 = 32'h40400000; n2 = 32'h3F000000; sub = 1'b1; stall = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midop_reset_done", {31'b0, done}, 32'd0);
        chk("midop_reset_result", res, 32'd0);
        reset = 1'b0;
        stall = 1'b0;
        go    = 1'b0;
        @(negedge clk);
        chk("midop_after_result", res, 32'd0);
        for (int k = 0; k < 10; k++) begin
            chk("midop_no_done", {31'b0, done}, 32'd0);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_add_pipe.md
Name: fp_add_pipe

Overview:
- Parametrised, pipelined IEEE-754 style floating-point adder/subtractor.
- Fixed 4-stage pipeline accepts one operation per cycle on `_go` and produces a `done` pulse aligned with Result.
- Adds hidden-bit handling, leading-zero normalisation, special-value handling and a global `stall` to the datapath.
- Sits beside the combinational adder in the floating-point test suite as the timing-closed, pipelined variant.

Parameters:
- EXP_W, 8: exponent field width; bias = 2^(EXP_W-1)-1.
- MAN_W, 23: stored mantissa (fraction) width, hidden bit excluded.
- W, 1+EXP_W+MAN_W: total word width; derived, not overridable.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- _go  in  1  operation valid; operands sampled at this edge when stall=0.
- stall  in  1  freezes all pipeline registers, including valid bits.
- sub  in  1  1: compute Number1-Number2 (Number2 sign inverted at stage 1).
- Number1  in  W  operand A {sign, exp, frac}.
- Number2  in  W  operand B.
- Result  out  W  sum; valid only while done=1.
- done  out  1  result valid; 1-cycle pulse per issued op, absent stalls.

Behaviour:
- Reset: sync, active-high; clears all stage valid bits; done=0, Result=0 while reset is high and the cycle after.
- Reset mid-operation: ops in flight are discarded, no done is produced for them.
- Latency: op accepted at edge N (`_go`=1, stall=0) gives done=1 and Result after edge N+4. Throughput is 1 op/cycle.
- `_go` while stall=1 is ignored; the issuer must hold it.
- Stall: every stage register and valid bit holds. done/Result hold their value; done stays high if it was high. The consumer must treat done as a level qualified by !stall.
- S1, unpack/classify:
  - Class is ZERO (exp=0; denormals flushed to zero), INF (exp all-ones, frac=0), NAN (exp all-ones, frac≠0) or NORM.
  - Hidden bit is prepended to NORM operands.
  - Operands are swapped so the larger magnitude (exp, then frac) is "L".
  - d = eL-eS computed at EXP_W bits.
- S2, align: S mantissa is shifted right by d, extended with guard, round and sticky bits; sticky = OR of all bits shifted out. If d ≥ MAN_W+3, S becomes sticky-only.
- S3, add/sub:
  - Effective subtract when signs differ.
  - Sum width MAN_W+5, including carry.
  - Leading-zero count comes from sub-module fp_lzc.
- S4, normalise/pack:
  - On carry: shift right 1 (sticky absorbs), exp+1.
  - Otherwise: shift left by lzc, exp-lzc.
  - Then round (see optional feature).
  - Post-round carry renormalises once more.
- Result sign = sign of L. Exact cancellation gives +0.
- Overflow: final exp ≥ all-ones gives ±INF (frac=0).
- Underflow: final exp ≤ 0 gives ±0 (flush).
- Specials override the datapath at S4, carried down as class flags:
  - Any NAN, or INF + (-INF) after sub adjustment: canonical qNaN {0, all-ones, 1 followed by zeros}.
  - Otherwise any INF: that INF with its effective sign.
  - ZERO + x = x, exact. (+0)+(-0) = +0; (-0)+(-0) = -0.

Optional Feature:
- FP_ADD_ROUND_EN defined: round-to-nearest-even using guard/round/sticky. Increment if G & (R | S | lsb).
- Undefined: truncate toward zero. G/R/S are still computed but ignored, so the rounding-incrementer logic is absent.
- Latency is identical in both builds.

Decomposition:
- Package fp_pkg holds:
  - fp_class_t enum {FP_ZERO, FP_NORM, FP_INF, FP_NAN}.
  - Localparam functions for bias, all-ones exponent and qNaN pattern from EXP_W/MAN_W.
  - Stage payload struct typedefs.
  - LATENCY=4 constant.
- Sub-module fp_lzc #(WIDTH): combinational leading-zero counter, output width $clog2(WIDTH+1). All-zero input gives count WIDTH.

Test Plan:
- 0x3F800000 + 0x3F800000, `_go` at cycle 0 → done at cycle 4, Result 0x40000000. done low on all other cycles.
- 0x3FC00000 + 0xBFC00000 → 0x00000000. 0x80000000 + 0x80000000 → 0x80000000.
- 0x7F800000 + 0xFF800000 → 0x7FC00000. 0x7F800000 + 0x3F800000 → 0x7F800000. 0x7FA00000 + 1.0 → 0x7FC00000.
- 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000.
- 0x3F800000 + 0x33C00000:
  - with ROUND_EN → 0x3F800001; without → 0x3F800000.
  - 0x3F800000 + 0x33800000 → 0x3F800000 (tie to even).
- Ops A, B, C on consecutive cycles; stall high for 2 cycles after B issues → three done pulses in order, Result values correct. Reset asserted during the stall → no further done pulses.
